// File: rtl/vga_controller.sv
// ---------------------------------------------------------------------------
// vga_controller
//
// 640x480 @ 60 Hz VGA timing generator with a simple score display.
// While the game runs, the score is drawn as a row of green segments on a
// dark-blue background. Once the game is over, the whole visible area turns
// red.
//
// Parameters
//   SEG_WIDTH  : width in pixels of one score segment (last 4 columns are a gap)
//   MAX_SEGS   : maximum number of segments drawn
//   H_* / V_*  : raster geometry (visible, front porch, sync, back porch)
//   BAR_TOP    : first row of the segment bar
//   BAR_BOTTOM : last row of the segment bar (inclusive)
//
// Ports
//   ingame   in   1 = game running, 0 = game over
//   score    in   current score, unsigned
//   clk25    in   25 MHz pixel clock, the only clock
//   reset    in   synchronous, active-high reset
//   hSync    out  horizontal sync, active low
//   vSync    out  vertical sync, active low
//   VGA_R/G/B out 4-bit colour channels
//   ps2_clk  io   reserved, always high-impedance
//   ps2_data io   reserved, always high-impedance
//
// Timing: hSync, vSync and RGB are all registered from the same counter
// state, so each pin shows the pixel addressed by the counters one clock
// earlier. ingame and score are captured at the first pixel of a frame and
// held for the rest of it.
// ---------------------------------------------------------------------------
module vga_controller #(
  parameter int SEG_WIDTH  = 50,
  parameter int MAX_SEGS   = 12,
  parameter int H_VISIBLE  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter int BAR_TOP    = 200,
  parameter int BAR_BOTTOM = 279
) (
  input  logic        ingame,
  input  logic [31:0] score,
  input  logic        clk25,
  input  logic        reset,
  output logic        hSync,
  output logic        vSync,
  output logic [3:0]  VGA_R,
  output logic [3:0]  VGA_G,
  output logic [3:0]  VGA_B,
  inout  wire         ps2_clk,
  inout  wire         ps2_data
);

  // -------------------------------------------------------------------------
  // Geometry
  // -------------------------------------------------------------------------
  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int SXW     = $clog2(SEG_WIDTH);
  localparam int SEGW    = $clog2(MAX_SEGS + 1);

  localparam logic [HW-1:0]   H_LAST       = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0]   H_VIS_END    = HW'(H_VISIBLE);
  localparam logic [HW-1:0]   H_SYNC_FIRST = HW'(H_VISIBLE + H_FRONT);
  localparam logic [HW-1:0]   H_SYNC_LAST  = HW'(H_VISIBLE + H_FRONT + H_SYNC - 1);

  localparam logic [VW-1:0]   V_LAST       = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0]   V_VIS_END    = VW'(V_VISIBLE);
  localparam logic [VW-1:0]   V_SYNC_FIRST = VW'(V_VISIBLE + V_FRONT);
  localparam logic [VW-1:0]   V_SYNC_LAST  = VW'(V_VISIBLE + V_FRONT + V_SYNC - 1);
  localparam logic [VW-1:0]   V_BAR_TOP    = VW'(BAR_TOP);
  localparam logic [VW-1:0]   V_BAR_BOTTOM = VW'(BAR_BOTTOM);

  localparam logic [SXW-1:0]  SX_LAST      = SXW'(SEG_WIDTH - 1);
  localparam logic [SXW-1:0]  SX_GAP_FIRST = SXW'(SEG_WIDTH - 4);
  localparam logic [SEGW-1:0] SEGS_MAX     = SEGW'(MAX_SEGS);
  localparam logic [31:0]     SCORE_CAP    = 32'(MAX_SEGS);

  // Colours as {R, G, B}
  localparam logic [11:0] RGB_BLACK = 12'h000;
  localparam logic [11:0] RGB_RED   = 12'hF00;
  localparam logic [11:0] RGB_GREEN = 12'h0F0;
  localparam logic [11:0] RGB_BLUE  = 12'h004;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [HW-1:0]   h_count;
  logic [VW-1:0]   v_count;
  logic [SXW-1:0]  seg_x;       // column inside the current segment slot
  logic [SEGW-1:0] seg_idx;     // index of the current segment slot, saturating
  logic            ingame_q;
  logic [31:0]     score_q;

  // -------------------------------------------------------------------------
  // Combinational pixel decode
  // -------------------------------------------------------------------------
  logic            frame_start;
  logic            ingame_eff;
  logic [31:0]     score_eff;
  logic [SEGW-1:0] segs;
  logic            visible;
  logic            bar_row;
  logic            seg_on;
  logic            h_sync_act;
  logic            v_sync_act;
  logic [11:0]     pix_rgb;

  always_comb begin
    frame_start = (h_count == '0) && (v_count == '0);

    // The first pixel of a frame is drawn with the values being captured on
    // that same edge, so every pixel of a frame sees one consistent pair.
    ingame_eff  = frame_start ? ingame : ingame_q;
    score_eff   = frame_start ? score  : score_q;

    // Full 32-bit compare: any score at or above the cap draws MAX_SEGS.
    segs        = (score_eff >= SCORE_CAP) ? SEGS_MAX : score_eff[SEGW-1:0];

    visible     = (h_count < H_VIS_END) && (v_count < V_VIS_END);
    bar_row     = (v_count >= V_BAR_TOP) && (v_count <= V_BAR_BOTTOM);
    seg_on      = (seg_idx < segs) && (seg_x < SX_GAP_FIRST);

    h_sync_act  = (h_count >= H_SYNC_FIRST) && (h_count <= H_SYNC_LAST);
    v_sync_act  = (v_count >= V_SYNC_FIRST) && (v_count <= V_SYNC_LAST);

    pix_rgb = RGB_BLACK;
    if (visible) begin
      if (!ingame_eff) begin
        pix_rgb = RGB_RED;
      end else if (bar_row && seg_on) begin
        pix_rgb = RGB_GREEN;
      end else begin
        pix_rgb = RGB_BLUE;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Raster counters
  // -------------------------------------------------------------------------
  always_ff @(posedge clk25) begin
    if (reset) begin
      h_count <= '0;
      v_count <= '0;
    end else if (h_count == H_LAST) begin
      h_count <= '0;
      v_count <= (v_count == V_LAST) ? '0 : v_count + 1'b1;
    end else begin
      h_count <= h_count + 1'b1;
    end
  end

  // Segment position tracks h_count incrementally, which avoids a divider
  // for "x mod SEG_WIDTH" and a multiplier for "segs * SEG_WIDTH". The slot
  // index stops at MAX_SEGS because nothing past it is ever drawn.
  always_ff @(posedge clk25) begin
    if (reset || (h_count == H_LAST)) begin
      seg_x   <= '0;
      seg_idx <= '0;
    end else if (seg_x == SX_LAST) begin
      seg_x <= '0;
      if (seg_idx != SEGS_MAX) begin
        seg_idx <= seg_idx + 1'b1;
      end
    end else begin
      seg_x <= seg_x + 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Per-frame input capture
  // -------------------------------------------------------------------------
  always_ff @(posedge clk25) begin
    if (reset) begin
      ingame_q <= 1'b0;
      score_q  <= '0;
    end else if (frame_start) begin
      ingame_q <= ingame;
      score_q  <= score;
    end
  end

  // -------------------------------------------------------------------------
  // Output registers: one common stage for sync and colour
  // -------------------------------------------------------------------------
  always_ff @(posedge clk25) begin
    if (reset) begin
      hSync <= 1'b1;
      vSync <= 1'b1;
      VGA_R <= '0;
      VGA_G <= '0;
      VGA_B <= '0;
    end else begin
      hSync <= ~h_sync_act;
      vSync <= ~v_sync_act;
      VGA_R <= pix_rgb[11:8];
      VGA_G <= pix_rgb[7:4];
      VGA_B <= pix_rgb[3:0];
    end
  end

  // PS/2 lines are reserved for a future keyboard interface.
  assign ps2_clk  = 1'bz;
  assign ps2_data = 1'bz;

endmodule

// File: tb/tb_vga_controller.sv
// ---------------------------------------------------------------------------
// tb_vga_controller
//
// Full horizontal timing, shortened vertical timing (10 lines per frame,
// visible rows 0..5, vSync on lines 7..8, bar on rows 2..3) so that several
// frames fit in a short run.
//
// Pin sample at cycle n (n = posedges since reset release) shows pixel
// p = n - 1, i.e. frame p / 8000, line (p % 8000) / 800, column p % 800.
// Inputs for frame k+1 are changed on line 1 of frame k, so every frame also
// shows that mid-frame changes are ignored until the next frame start.
// ---------------------------------------------------------------------------
module tb_vga_controller;

  localparam int unsigned LINE  = 800;
  localparam int unsigned FRAME = 8000;

  localparam logic [11:0] GRN = 12'h0F0;
  localparam logic [11:0] BLU = 12'h004;
  localparam logic [11:0] RED = 12'hF00;
  localparam logic [11:0] BLK = 12'h000;

  // ---------------- clock / reset ----------------
  logic        clk25  = 1'b0;
  logic        reset  = 1'b1;
  logic        ingame = 1'b0;
  logic [31:0] score  = 32'd0;

  logic        hSync;
  logic        vSync;
  logic [3:0]  VGA_R;
  logic [3:0]  VGA_G;
  logic [3:0]  VGA_B;
  wire         ps2_clk_w;
  wire         ps2_data_w;

  always #20 clk25 = ~clk25;

  int unsigned cyc = 0;
  always @(posedge clk25) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  vga_controller #(
    .SEG_WIDTH  (50),
    .MAX_SEGS   (12),
    .V_VISIBLE  (6),
    .V_FRONT    (1),
    .V_SYNC     (2),
    .V_BACK     (1),
    .BAR_TOP    (2),
    .BAR_BOTTOM (3)
  ) dut (
    .ingame   (ingame),
    .score    (score),
    .clk25    (clk25),
    .reset    (reset),
    .hSync    (hSync),
    .vSync    (vSync),
    .VGA_R    (VGA_R),
    .VGA_G    (VGA_G),
    .VGA_B    (VGA_B),
    .ps2_clk  (ps2_clk_w),
    .ps2_data (ps2_data_w)
  );

  // ---------------- scoreboard ----------------
  logic [13:0] exp_q[$];     // {hSync, vSync, R, G, B}
  int unsigned exp_n_q[$];   // cycle at which the entry is due
  int n_compared = 0;
  int n_mismatch = 0;

  // ---------------- driver tasks ----------------
  task automatic px(input int unsigned k, input int unsigned line, input int unsigned h,
                    input logic hs, input logic vs, input logic [11:0] rgb);
    exp_n_q.push_back(k * FRAME + line * LINE + h + 1);
    exp_q.push_back({hs, vs, rgb});
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatch++;
      $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic wait_cyc(input int unsigned t);
    while (cyc < t) @(negedge clk25);
  endtask

  task automatic hold_reset_and_check(input string tag);
    reset = 1'b1;
    repeat (3) @(posedge clk25);
    @(negedge clk25);
    check({tag, "_hsync"}, 32'(hSync), 32'd1);
    check({tag, "_vsync"}, 32'(vSync), 32'd1);
    check({tag, "_rgb"},   32'({VGA_R, VGA_G, VGA_B}), 32'd0);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk25) begin
    if (!reset) begin
      while (exp_n_q.size() > 0 && exp_n_q[0] <= cyc) begin
        logic [13:0] act;
        logic [13:0] exp;
        int unsigned p;
        act = {hSync, vSync, VGA_R, VGA_G, VGA_B};
        exp = exp_q[0];
        p   = exp_n_q[0] - 1;
        n_compared++;
        if (exp_n_q[0] < cyc) begin
          n_mismatch++;
          $display("FAIL pixel_missed: due at cycle %0d, now %0d", exp_n_q[0], cyc);
        end else if (act !== exp) begin
          n_mismatch++;
          $display("FAIL pixel cyc=%0d frame=%0d line=%0d h=%0d: got hs=%b vs=%b rgb=%03h, want hs=%b vs=%b rgb=%03h",
                   cyc, p / FRAME, (p % FRAME) / LINE, p % LINE,
                   act[13], act[12], act[11:0], exp[13], exp[12], exp[11:0]);
        end
        void'(exp_q.pop_front());
        void'(exp_n_q.pop_front());
      end
    end
  end

  // ---------------- sync edge recorder ----------------
  bit          measuring = 1'b0;
  logic        prev_hs   = 1'b1;
  logic        prev_vs   = 1'b1;
  int unsigned hs_fall[$];
  int unsigned hs_rise[$];
  int unsigned vs_fall[$];
  int unsigned vs_rise[$];

  always @(negedge clk25) begin
    if (measuring && !reset) begin
      if (prev_hs && !hSync)  hs_fall.push_back(cyc);
      if (!prev_hs && hSync)  hs_rise.push_back(cyc);
      if (prev_vs && !vSync)  vs_fall.push_back(cyc);
      if (!prev_vs && vSync)  vs_rise.push_back(cyc);
      prev_hs = hSync;
      prev_vs = vSync;
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #(40 * 200000);
    n_mismatch++;
    $display("FAIL watchdog: run did not complete, cycle %0d", cyc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    ingame = 1'b1;
    score  = 32'd3;
    hold_reset_and_check("reset");

    // Frame 0: score 3
    px(0, 0,   0, 1, 1, BLU);
    px(0, 1,  10, 1, 1, BLU);
    px(0, 2,   0, 1, 1, GRN);
    px(0, 2,  45, 1, 1, GRN);
    px(0, 2,  46, 1, 1, BLU);
    px(0, 2,  49, 1, 1, BLU);
    px(0, 2,  50, 1, 1, GRN);
    px(0, 2,  95, 1, 1, GRN);
    px(0, 2,  96, 1, 1, BLU);
    px(0, 2, 100, 1, 1, GRN);
    px(0, 2, 145, 1, 1, GRN);
    px(0, 2, 146, 1, 1, BLU);
    px(0, 2, 150, 1, 1, BLU);
    px(0, 2, 639, 1, 1, BLU);
    px(0, 2, 640, 1, 1, BLK);
    px(0, 2, 655, 1, 1, BLK);
    px(0, 2, 656, 0, 1, BLK);
    px(0, 2, 751, 0, 1, BLK);
    px(0, 2, 752, 1, 1, BLK);
    px(0, 2, 799, 1, 1, BLK);
    px(0, 3,  10, 1, 1, GRN);
    px(0, 4,  10, 1, 1, BLU);
    px(0, 5,   0, 1, 1, BLU);
    px(0, 6,   0, 1, 1, BLK);
    px(0, 6, 799, 1, 1, BLK);
    px(0, 7,   0, 1, 0, BLK);
    px(0, 8, 700, 0, 0, BLK);
    px(0, 8, 799, 1, 0, BLK);
    px(0, 9,   0, 1, 1, BLK);
    // Frame 1: score 20 -> capped at 12 segments
    px(1, 2,   0, 1, 1, GRN);
    px(1, 2, 549, 1, 1, BLU);
    px(1, 2, 550, 1, 1, GRN);
    px(1, 2, 595, 1, 1, GRN);
    px(1, 2, 596, 1, 1, BLU);
    px(1, 2, 599, 1, 1, BLU);
    px(1, 2, 600, 1, 1, BLU);
    px(1, 2, 639, 1, 1, BLU);
    px(1, 2, 640, 1, 1, BLK);
    // Frame 2: score 0xFFFFFFFF -> 12 segments
    px(2, 3,   0, 1, 1, GRN);
    px(2, 3, 546, 1, 1, BLU);
    px(2, 3, 595, 1, 1, GRN);
    px(2, 3, 596, 1, 1, BLU);
    px(2, 3, 600, 1, 1, BLU);
    // Frame 3: score 0x00010000 -> 12 segments (low bits alone would give 0)
    px(3, 2,   0, 1, 1, GRN);
    px(3, 2, 595, 1, 1, GRN);
    px(3, 2, 600, 1, 1, BLU);
    // Frame 4: game over -> red
    px(4, 0,   0, 1, 1, RED);
    px(4, 2,   0, 1, 1, RED);
    px(4, 2, 639, 1, 1, RED);
    px(4, 2, 640, 1, 1, BLK);
    px(4, 3, 100, 1, 1, RED);
    px(4, 5, 639, 1, 1, RED);
    px(4, 6,   0, 1, 1, BLK);
    // Frame 5: score 0 -> all blue
    px(5, 2,   0, 1, 1, BLU);
    px(5, 2,  45, 1, 1, BLU);
    px(5, 3,   0, 1, 1, BLU);
    // Frame 6: score 2 (changed to 5 on line 1)
    px(6, 2,   0, 1, 1, GRN);
    px(6, 2,  95, 1, 1, GRN);
    px(6, 2,  96, 1, 1, BLU);
    px(6, 2, 100, 1, 1, BLU);
    px(6, 2, 145, 1, 1, BLU);
    // Frame 7: score 5
    px(7, 2, 100, 1, 1, GRN);
    px(7, 2, 245, 1, 1, GRN);
    px(7, 2, 246, 1, 1, BLU);
    px(7, 2, 250, 1, 1, BLU);
    px(7, 3, 200, 1, 1, GRN);

    measuring = 1'b1;
    reset     = 1'b0;

    wait_cyc(0 * FRAME + LINE);  ingame = 1'b1; score = 32'd20;
    wait_cyc(1 * FRAME + LINE);  ingame = 1'b1; score = 32'hFFFF_FFFF;

    wait_cyc(2 * FRAME);
    measuring = 1'b0;
    check("hsync_fall_count", 32'(hs_fall.size()), 32'd20);
    if (hs_fall.size() >= 2 && hs_rise.size() >= 1) begin
      check("hsync_first_fall", hs_fall[0], 32'd657);
      check("hsync_period", hs_fall[1] - hs_fall[0], 32'd800);
      check("hsync_low_width", hs_rise[0] - hs_fall[0], 32'd96);
    end
    check("vsync_fall_count", 32'(vs_fall.size()), 32'd2);
    if (vs_fall.size() >= 2 && vs_rise.size() >= 1) begin
      check("vsync_first_fall", vs_fall[0], 32'd5601);
      check("vsync_period", vs_fall[1] - vs_fall[0], 32'd8000);
      check("vsync_low_width", vs_rise[0] - vs_fall[0], 32'd1600);
    end

    wait_cyc(2 * FRAME + LINE);  ingame = 1'b1; score = 32'h0001_0000;
    wait_cyc(3 * FRAME + LINE);  ingame = 1'b0; score = 32'd7;
    wait_cyc(4 * FRAME + LINE);  ingame = 1'b1; score = 32'd0;
    wait_cyc(5 * FRAME + LINE);  ingame = 1'b1; score = 32'd2;
    wait_cyc(6 * FRAME + LINE);  ingame = 1'b1; score = 32'd5;

    // Abort frame 7 in the middle of a green segment on line 3.
    wait_cyc(7 * FRAME + 3 * LINE + 202);
    check("probes_done_before_abort", 32'(exp_q.size()), 32'd0);
    ingame = 1'b1;
    score  = 32'd1;
    hold_reset_and_check("midframe_reset");

    // After release: restart from (0,0), inputs taken on the first edge.
    px(0, 0,   0, 1, 1, BLU);
    px(0, 0, 639, 1, 1, BLU);
    px(0, 0, 640, 1, 1, BLK);
    px(0, 0, 655, 1, 1, BLK);
    px(0, 0, 656, 0, 1, BLK);
    px(0, 0, 751, 0, 1, BLK);
    px(0, 0, 752, 1, 1, BLK);
    px(0, 2,   0, 1, 1, GRN);
    px(0, 2,  45, 1, 1, GRN);
    px(0, 2,  46, 1, 1, BLU);
    px(0, 2,  50, 1, 1, BLU);
    px(0, 7,   0, 1, 0, BLK);
    reset = 1'b0;

    wait_cyc(7 * LINE + 2);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

endmodule
